// File: rtl/search_coordinator.sv
// Iterative-deepening scheduler for the sequence generator.
// Sweeps lengths 1..N, tracks first match, match count and a per-length watchdog.
module search_coordinator #(
    parameter int SEQ_INDEX_BITS  = 4,
    parameter int COUNT_BITS      = 16,
    parameter int WATCHDOG_CYCLES = 0,
    parameter bit STOP_ON_MATCH   = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      go,
    input  logic                      abort,
    input  logic [SEQ_INDEX_BITS-1:0] target_max_length,
    output logic [SEQ_INDEX_BITS-1:0] gen_max_length,
    output logic                      gen_start,
    input  logic                      gen_complete,
    input  logic                      match,
    output logic                      busy,
    output logic                      done,
    output logic                      found,
    output logic [SEQ_INDEX_BITS-1:0] found_length,
    output logic [COUNT_BITS-1:0]     match_count,
    output logic                      timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_ARMED,
        S_RUN,
        S_FINISH
    } state_t;

    localparam bit          WD_EN   = (WATCHDOG_CYCLES != 0);
    localparam logic [31:0] WD_LAST = 32'(WATCHDOG_CYCLES) - 32'd1;
    localparam logic [SEQ_INDEX_BITS-1:0] LEN_ONE = 1;
    localparam logic [COUNT_BITS-1:0]     CNT_ONE = 1;

    state_t                    state_q, state_d;
    logic [SEQ_INDEX_BITS-1:0] cur_len_q, cur_len_d;
    logic [SEQ_INDEX_BITS-1:0] tgt_len_q, tgt_len_d;
    logic                      found_q, found_d;
    logic [SEQ_INDEX_BITS-1:0] found_length_q, found_length_d;
    logic [COUNT_BITS-1:0]     match_count_q, match_count_d;
    logic                      timeout_q, timeout_d;
    logic [31:0]               wd_cnt_q, wd_cnt_d;

    logic match_act;
    logic found_next;
    logic wd_hit;

    assign wd_hit = WD_EN && (wd_cnt_q == WD_LAST);

    // Next-state, sweep bookkeeping and match tracking.
    always_comb begin
        state_d        = state_q;
        cur_len_d      = cur_len_q;
        tgt_len_d      = tgt_len_q;
        found_d        = found_q;
        found_length_d = found_length_q;
        match_count_d  = match_count_q;
        timeout_d      = timeout_q;
        wd_cnt_d       = wd_cnt_q;

        // Matches only count while the generator is working on a length.
        match_act  = match && (state_q == S_ARMED || state_q == S_RUN);
        found_next = found_q | match_act;

        if (match_act) begin
            if (match_count_q != '1) begin
                match_count_d = match_count_q + CNT_ONE;
            end
            if (!found_q) begin
                found_d        = 1'b1;
                found_length_d = cur_len_q;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (go && !abort) begin
                    tgt_len_d      = target_max_length;
                    found_d        = 1'b0;
                    found_length_d = '0;
                    match_count_d  = '0;
                    timeout_d      = 1'b0;
                    if (target_max_length == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        cur_len_d = LEN_ONE;
                        state_d   = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                wd_cnt_d = '0;
                state_d  = S_ARMED;
            end
            // gen_complete is still the previous length's level here.
            S_ARMED: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                wd_cnt_d = wd_cnt_q + 32'd1;
                if (gen_complete) begin
                    if (cur_len_q == tgt_len_q ||
                        (STOP_ON_MATCH && found_next)) begin
                        state_d = S_FINISH;
                    end else begin
                        cur_len_d = cur_len_q + LEN_ONE;
                        state_d   = S_LAUNCH;
                    end
                end else if (wd_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort drops straight to idle and freezes the status registers.
        if (abort && state_q != S_IDLE) begin
            state_d        = S_IDLE;
            cur_len_d      = cur_len_q;
            found_d        = found_q;
            found_length_d = found_length_q;
            match_count_d  = match_count_q;
            timeout_d      = timeout_q;
            wd_cnt_d       = wd_cnt_q;
        end
    end

    // State and status registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cur_len_q      <= '0;
            tgt_len_q      <= '0;
            found_q        <= 1'b0;
            found_length_q <= '0;
            match_count_q  <= '0;
            timeout_q      <= 1'b0;
            wd_cnt_q       <= '0;
        end else begin
            state_q        <= state_d;
            cur_len_q      <= cur_len_d;
            tgt_len_q      <= tgt_len_d;
            found_q        <= found_d;
            found_length_q <= found_length_d;
            match_count_q  <= match_count_d;
            timeout_q      <= timeout_d;
            wd_cnt_q       <= wd_cnt_d;
        end
    end

    assign gen_start      = (state_q == S_LAUNCH);
    assign done           = (state_q == S_FINISH);
    assign busy           = (state_q != S_IDLE);
    assign gen_max_length = cur_len_q;
    assign found          = found_q;
    assign found_length   = found_length_q;
    assign match_count    = match_count_q;
    assign timeout        = timeout_q;

endmodule

// File: tb/tb_search_coordinator.sv
// Directed bench for search_coordinator: two instances (stop-on-match with
// watchdog, and full sweep with a narrow counter) driven from shared stimulus.
module tb_search_coordinator;

    logic       clk = 1'b0;
    logic       reset;
    logic       go;
    logic       abort;
    logic [3:0] target;
    logic       match;
    int         gen_delay;

    logic        a_gs, a_busy, a_done, a_found, a_to, a_gc;
    logic [3:0]  a_gml, a_fl;
    logic [15:0] a_mc;
    logic        b_gs, b_busy, b_done, b_found, b_to, b_gc;
    logic [3:0]  b_gml, b_fl;
    logic [2:0]  b_mc;

    int a_cnt, b_cnt;
    int a_starts = 0, b_starts = 0, a_dones = 0, b_dones = 0;
    logic [3:0] a_len_log [0:63];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    search_coordinator #(
        .SEQ_INDEX_BITS(4), .COUNT_BITS(16),
        .WATCHDOG_CYCLES(20), .STOP_ON_MATCH(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .go(go), .abort(abort),
        .target_max_length(target), .gen_max_length(a_gml),
        .gen_start(a_gs), .gen_complete(a_gc), .match(match),
        .busy(a_busy), .done(a_done), .found(a_found),
        .found_length(a_fl), .match_count(a_mc), .timeout(a_to)
    );

    search_coordinator #(
        .SEQ_INDEX_BITS(4), .COUNT_BITS(3),
        .WATCHDOG_CYCLES(0), .STOP_ON_MATCH(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .go(go), .abort(abort),
        .target_max_length(target), .gen_max_length(b_gml),
        .gen_start(b_gs), .gen_complete(b_gc), .match(match),
        .busy(b_busy), .done(b_done), .found(b_found),
        .found_length(b_fl), .match_count(b_mc), .timeout(b_to)
    );

    // Generator models: complete drops after the stale cycle, rises gen_delay later.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            a_gc <= 1'b0;
            a_cnt <= 0;
        end else begin
            if (a_gs) a_cnt <= 1;
            else if (a_cnt != 0) a_cnt <= a_cnt + 1;
            if (a_cnt == 1) a_gc <= 1'b0;
            if (gen_delay != 0 && a_cnt == gen_delay) begin
                a_gc <= 1'b1;
                a_cnt <= 0;
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            b_gc <= 1'b0;
            b_cnt <= 0;
        end else begin
            if (b_gs) b_cnt <= 1;
            else if (b_cnt != 0) b_cnt <= b_cnt + 1;
            if (b_cnt == 1) b_gc <= 1'b0;
            if (gen_delay != 0 && b_cnt == gen_delay) begin
                b_gc <= 1'b1;
                b_cnt <= 0;
            end
        end
    end

    // Pulse monitors sampled mid-cycle.
    always @(negedge clk) begin
        if (a_gs) begin
            a_len_log[a_starts[5:0]] <= a_gml;
            a_starts <= a_starts + 1;
        end
        if (b_gs) b_starts <= b_starts + 1;
        if (a_done) a_dones <= a_dones + 1;
        if (b_done) b_dones <= b_dones + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        go = 1'b0;
        abort = 1'b0;
        match = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic start(input logic [3:0] t);
        target = t;
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_start(input bit use_b, input logic [3:0] len,
                              input string tag);
        int n = 0;
        while (n < 300 && !(use_b ? (b_gs && b_gml == len)
                                  : (a_gs && a_gml == len))) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < 300), 32'd1);
    endtask

    task automatic wait_done(input bit use_b, input string tag);
        int n = 0;
        while (n < 300 && !(use_b ? b_done : a_done)) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < 300), 32'd1);
    endtask

    int s0, d0, sb0;

    initial begin
        reset = 1'b1;
        go = 1'b0;
        abort = 1'b0;
        target = 4'd0;
        match = 1'b0;
        gen_delay = 10;
        tick();
        tick();
        chk("rst_ctl", {a_busy, a_done, a_gs, a_found, a_to}, 0);
        chk("rst_data", {a_gml, a_fl, a_mc}, 0);
        reset = 1'b0;
        tick();
        chk("idle_busy", a_busy, 0);

        // Plain sweep of three lengths, no matches.
        s0 = a_starts;
        d0 = a_dones;
        start(4'd3);
        chk("t1_latency_start", a_gs, 1);
        chk("t1_first_len", a_gml, 1);
        wait_done(1'b0, "t1_done_seen");
        chk("t1_found", a_found, 0);
        chk("t1_count", a_mc, 0);
        chk("t1_timeout", a_to, 0);
        tick();
        chk("t1_busy_after", a_busy, 0);
        chk("t1_done_once", a_dones - d0, 1);
        chk("t1_starts", a_starts - s0, 3);
        chk("t1_lens", {a_len_log[s0], a_len_log[s0+1], a_len_log[s0+2]},
            {4'd1, 4'd2, 4'd3});

        // Stop on first match at length 2.
        do_reset();
        s0 = a_starts;
        start(4'd4);
        wait_start(1'b0, 4'd2, "t2_len2_seen");
        tick();
        tick();
        tick();
        match = 1'b1;
        tick();
        match = 1'b0;
        chk("t2_found_early", {a_found, a_fl}, {1'b1, 4'd2});
        wait_done(1'b0, "t2_done_seen");
        chk("t2_starts", a_starts - s0, 2);
        chk("t2_found_len", a_fl, 2);
        chk("t2_count", a_mc, 1);

        // Full sweep on B with matches at lengths 2 and 3.
        do_reset();
        s0 = a_starts;
        sb0 = b_starts;
        start(4'd4);
        wait_start(1'b1, 4'd2, "t3_b_len2");
        tick();
        tick();
        match = 1'b1;
        tick();
        match = 1'b0;
        wait_start(1'b1, 4'd3, "t3_b_len3");
        tick();
        tick();
        match = 1'b1;
        tick();
        match = 1'b0;
        wait_done(1'b1, "t3_b_done");
        chk("t3_b_starts", b_starts - sb0, 4);
        chk("t3_b_found", {b_found, b_fl}, {1'b1, 4'd2});
        chk("t3_b_count", b_mc, 2);
        chk("t3_a_starts", a_starts - s0, 2);
        chk("t3_a_idle_ignore", a_mc, 1);

        // Watchdog fires when the generator never completes.
        do_reset();
        gen_delay = 0;
        start(4'd1);
        tick();
        for (int i = 0; i < 20; i++) tick();
        chk("t4_run20_nodone", {a_done, a_to}, 0);
        tick();
        chk("t4_timeout_done", {a_done, a_to}, 2'b11);
        tick();
        chk("t4_hold", {a_busy, a_to}, 2'b01);

        // Complete coincident with expiry wins.
        do_reset();
        gen_delay = 20;
        start(4'd1);
        tick();
        for (int i = 0; i < 20; i++) tick();
        chk("t5_gc_at_expiry", {a_gc, a_done}, 2'b10);
        tick();
        chk("t5_done_no_to", {a_done, a_to}, 2'b10);

        // Abort mid-run, then a zero-length search.
        do_reset();
        gen_delay = 10;
        s0 = a_starts;
        d0 = a_dones;
        start(4'd3);
        wait_start(1'b0, 4'd2, "t6_len2_seen");
        tick();
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_abort_idle", {a_busy, a_done}, 0);
        tick();
        tick();
        chk("t6_no_done", a_dones - d0, 0);
        go = 1'b1;
        abort = 1'b1;
        tick();
        go = 1'b0;
        abort = 1'b0;
        chk("t6_go_abort_ign", a_busy, 0);
        start(4'd0);
        chk("t6_t0_done", {a_done, a_gs, a_busy}, 3'b101);
        tick();
        chk("t6_t0_idle", {a_busy, a_found}, 0);
        chk("t6_t0_starts", a_starts - s0, 2);
        chk("t6_t0_dones", a_dones - d0, 1);

        // Asynchronous reset in the middle of a run.
        do_reset();
        gen_delay = 0;
        start(4'd4);
        tick();
        match = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        match = 1'b0;
        chk("t7_count5", {a_busy, a_mc}, {1'b1, 16'd5});
        #2;
        reset = 1'b1;
        #1;
        chk("t7_async_ctl", {a_busy, a_done, a_gs, a_found, a_to}, 0);
        chk("t7_async_data", {a_gml, a_fl, a_mc, b_mc}, 0);
        tick();
        reset = 1'b0;
        tick();

        // Counter saturation on the 3-bit instance.
        start(4'd1);
        tick();
        match = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        match = 1'b0;
        chk("t8_b_saturate", b_mc, 7);
        chk("t8_a_no_sat", a_mc, 11);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/search_coordinator.md
Name: search_coordinator

Overview:
- Top-level scheduler for the sequence generator.
- Runs an iterative-deepening search: sweeps sequence length 1..N, and for each length pulses the generator's start and waits for its complete.
- Watches a match pulse from the product comparator; records the first matching length and counts matches.
- Sits between the host/UART command logic and the sequence generator. Provides a per-length watchdog.

Parameters:
SEQ_INDEX_BITS, 4, width of sequence lengths (matches the generator's max_length port)
COUNT_BITS, 16, width of the saturating match counter
WATCHDOG_CYCLES, 0, cycles allowed per length before timeout; 0 disables the watchdog
STOP_ON_MATCH, 1, 1 = finish after the length in which the first match occurred; 0 = sweep all lengths

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
go  in  1  pulse; starts a search when idle
abort  in  1  level/pulse; cancels a search
target_max_length  in  SEQ_INDEX_BITS  longest length to try; sampled on go
gen_max_length  out  SEQ_INDEX_BITS  length driven to the generator
gen_start  out  1  one-cycle start pulse to the generator
gen_complete  in  1  generator done level; cleared by the generator one cycle after start
match  in  1  one-cycle pulse: current product equals target
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at normal finish or timeout (never on abort)
found  out  1  held high once a match has been seen in this search
found_length  out  SEQ_INDEX_BITS  length at first match; valid when found=1
match_count  out  COUNT_BITS  saturating count of match pulses in this search
timeout  out  1  held high if the watchdog fired in this search

Behaviour:
- Reset (async, any time, including mid-search):
  - state=IDLE; all outputs 0.
  - cur_len=0, tgt_len=0, wd_cnt=0.
- Outputs decoded from registered state:
  - gen_start=1 iff state==LAUNCH.
  - done=1 iff state==FINISH.
  - busy=1 iff state!=IDLE.
  - gen_max_length=cur_len, a register that is stable for the whole length.
- States: IDLE, LAUNCH, ARMED, RUN, FINISH.
- IDLE:
  - go && !abort:
    - tgt_len<=target_max_length.
    - Clear found, found_length, match_count, timeout.
    - If target_max_length==0 -> FINISH, found stays 0.
    - Else cur_len<=1 -> LAUNCH.
  - go && abort in the same cycle: go is ignored.
- LAUNCH (exactly 1 cycle): wd_cnt<=0 -> ARMED.
- ARMED (1 cycle; gen_complete is ignored because it is the stale value from the previous length): -> RUN.
- RUN: wd_cnt increments every cycle.
  - If gen_complete:
    - If cur_len==tgt_len, or STOP_ON_MATCH && found_next: -> FINISH.
    - Else cur_len<=cur_len+1 -> LAUNCH.
  - Else if WATCHDOG_CYCLES!=0 && wd_cnt==WATCHDOG_CYCLES-1: timeout<=1 -> FINISH.
  - gen_complete in the same cycle as watchdog expiry: complete wins, timeout stays 0.
- FINISH (1 cycle): -> IDLE. found, found_length, match_count and timeout hold until the next accepted go.
- abort in LAUNCH/ARMED/RUN/FINISH: -> IDLE next edge. No done pulse. Status registers hold their current values. The generator is not stopped; the next go relaunches it via start, which the generator accepts from its WAITING state only.
- go while busy: ignored.
- Match handling, active in ARMED and RUN only; match in IDLE/LAUNCH/FINISH is ignored:
  - match_count<=match_count+1, saturating at all-ones (no wrap).
  - On the first match (found==0): found<=1, found_length<=cur_len.
  - found_next = found | (match in the current cycle). A match coincident with gen_complete therefore counts toward the stop decision.
- Arithmetic:
  - cur_len never exceeds tgt_len, which is ≤2^SEQ_INDEX_BITS-1, so there is no overflow.
  - wd_cnt is a 32-bit counter compared for equality.
- Latency: go at edge k -> gen_start high during cycle k+1. gen_complete seen in RUN -> next gen_start 1 cycle later (RUN->LAUNCH).

Test Plan:
- target=3, no match; gen model completes 10 cycles after each start:
  - Three gen_start pulses with gen_max_length 1, 2, 3.
  - done pulses once; found=0; match_count=0; busy low the cycle after done.
- target=4, STOP_ON_MATCH=1, match pulsed once during length 2:
  - Exactly two starts; found=1, found_length=2, match_count=1; done after length 2 completes.
- Same as above with STOP_ON_MATCH=0 and matches at lengths 2 and 3:
  - Four starts; found_length=2; match_count=2.
- WATCHDOG_CYCLES=20, gen never completes:
  - timeout=1 and done pulses 20 RUN cycles after the ARMED cycle.
  - With complete and expiry in the same cycle: timeout=0.
- Abort in RUN at length 2:
  - IDLE next edge; no done; busy=0.
  - A new go with target=0 gives done on the second edge, found=0, no gen_start.
- Reset asserted asynchronously mid-RUN with match_count=5:
  - All outputs 0 immediately without waiting for a clock edge.
- Separately, force 2^COUNT_BITS+3 matches:
  - match_count saturates at all-ones.
